// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the data cache.
// Imported by data_cache and dcache_array.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} dcache_state_t;

  localparam int DC_AW    = 32;
  localparam int DC_DW    = 32;
  localparam int DC_LINES = 16;
  localparam int DC_WPL   = 4;

  function automatic int byte_bits(int dw);
    return $clog2(dw / 8);
  endfunction

  function automatic int offset_bits(int dw, int wpl);
    return $clog2(dw / 8) + $clog2(wpl);
  endfunction

  function automatic int index_bits(int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(int aw, int dw, int lines, int wpl);
    return aw - offset_bits(dw, wpl) - index_bits(lines);
  endfunction

  localparam int OFFSET_BITS = offset_bits(DC_DW, DC_WPL);
  localparam int INDEX_BITS  = index_bits(DC_LINES);
  localparam int TAG_BITS    = tag_bits(DC_AW, DC_DW, DC_LINES, DC_WPL);

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage: one async read port, one byte-masked write
// port, per-line valid clear and tag commit.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int DW    = DC_DW,
  parameter int LINES = DC_LINES,
  parameter int WPL   = DC_WPL,
  parameter int TW    = TAG_BITS,
  parameter int IW    = INDEX_BITS,
  parameter int WW    = $clog2(DC_WPL)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   rd_index_i,
  input  logic [WW-1:0]   rd_word_i,
  output logic            rd_valid_o,
  output logic [TW-1:0]   rd_tag_o,
  output logic [DW-1:0]   rd_data_o,
  input  logic            wr_en_i,
  input  logic [IW-1:0]   wr_index_i,
  input  logic [WW-1:0]   wr_word_i,
  input  logic [DW/8-1:0] wr_be_i,
  input  logic [DW-1:0]   wr_data_i,
  input  logic            clr_en_i,
  input  logic [IW-1:0]   clr_index_i,
  input  logic            commit_en_i,
  input  logic [IW-1:0]   commit_index_i,
  input  logic [TW-1:0]   commit_tag_i
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TW-1:0]    tag_q  [LINES];
  logic [DW-1:0]    data_q [LINES][WPL];

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i][rd_word_i];

  // Next valid vector: clear on refill entry, set on line commit.
  always_comb begin
    valid_d = valid_q;
    if (clr_en_i) valid_d[clr_index_i] = 1'b0;
    if (commit_en_i) valid_d[commit_index_i] = 1'b1;
  end

  // Valid bits are the only reset state in the array.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag written when a refill completes.
  always_ff @(posedge clk) begin
    if (commit_en_i) tag_q[commit_index_i] <= commit_tag_i;
  end

  // Byte-masked data write (refill beats and store hits).
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int b = 0; b < DW / 8; b++) begin
        if (wr_be_i[b])
          data_q[wr_index_i][wr_word_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through no-write-allocate data cache.
// Optional hit/miss counters with DCACHE_STATS_EN.
module data_cache
  import dcache_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = DC_AW,
  parameter int DATA_WIDTH     = DC_DW,
  parameter int NUM_LINES      = DC_LINES,
  parameter int WORDS_PER_LINE = DC_WPL
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic                    cpu_byte,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    cpu_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
`endif
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int BE = DW / 8;
  localparam int BB = byte_bits(DW);
  localparam int WB = $clog2(WORDS_PER_LINE);
  localparam int IB = index_bits(NUM_LINES);
  localparam int TB = tag_bits(AW, DW, NUM_LINES, WORDS_PER_LINE);
  localparam int LB = AW - BB - WB;

  dcache_state_t state_q, state_d;
  logic [WB-1:0] beat_q, beat_d;
  logic [LB-1:0] line_q, line_d;

  logic [BB-1:0] byte_off;
  logic [WB-1:0] word_sel;
  logic [IB-1:0] idx;
  logic [TB-1:0] tag;

  assign byte_off = cpu_addr[BB-1:0];
  assign word_sel = cpu_addr[BB +: WB];
  assign idx      = cpu_addr[BB+WB +: IB];
  assign tag      = cpu_addr[AW-1 -: TB];

  logic          rd_valid;
  logic [TB-1:0] rd_tag;
  logic [DW-1:0] rd_data;
  logic          hit;

  logic          wr_en;
  logic [IB-1:0] wr_index;
  logic [WB-1:0] wr_word;
  logic [BE-1:0] wr_be;
  logic [DW-1:0] wr_data;
  logic          clr_en;
  logic          commit_en;

  logic [BE-1:0] st_be;
  logic [DW-1:0] st_data;
  logic [7:0]    rd_byte;

  assign hit     = rd_valid && (rd_tag == tag);
  assign st_be   = cpu_byte ? (BE'(1) << byte_off) : '1;
  assign st_data = cpu_byte ? {BE{cpu_wdata[7:0]}} : cpu_wdata;
  assign rd_byte = rd_data[{byte_off, 3'b000} +: 8];

  assign cpu_rdata = cpu_byte ? {{(DW-8){1'b0}}, rd_byte} : rd_data;

  dcache_array #(
    .DW    (DW),
    .LINES (NUM_LINES),
    .WPL   (WORDS_PER_LINE),
    .TW    (TB),
    .IW    (IB),
    .WW    (WB)
  ) u_array (
    .clk            (clk),
    .rst            (rst),
    .rd_index_i     (idx),
    .rd_word_i      (word_sel),
    .rd_valid_o     (rd_valid),
    .rd_tag_o       (rd_tag),
    .rd_data_o      (rd_data),
    .wr_en_i        (wr_en),
    .wr_index_i     (wr_index),
    .wr_word_i      (wr_word),
    .wr_be_i        (wr_be),
    .wr_data_i      (wr_data),
    .clr_en_i       (clr_en),
    .clr_index_i    (idx),
    .commit_en_i    (commit_en),
    .commit_index_i (line_q[IB-1:0]),
    .commit_tag_i   (line_q[LB-1 -: TB])
  );

  // State, refill beat and latched refill line; line survives a dropped cpu_req.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
    end
  end

  // Next state, bus outputs and array write steering.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    line_d    = line_q;
    cpu_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    wr_en     = 1'b0;
    wr_index  = idx;
    wr_word   = word_sel;
    wr_be     = st_be;
    wr_data   = st_data;
    clr_en    = 1'b0;
    commit_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            state_d = WRITE;
          end else if (hit) begin
            cpu_ready = 1'b1;
          end else begin
            state_d = REFILL;
            clr_en  = 1'b1;
            line_d  = {tag, idx};
            beat_d  = '0;
          end
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {line_q, beat_q, {BB{1'b0}}};
        if (mem_ready) begin
          wr_en    = 1'b1;
          wr_index = line_q[IB-1:0];
          wr_word  = beat_q;
          wr_be    = '1;
          wr_data  = mem_rdata;
          if (beat_q == WB'(WORDS_PER_LINE - 1)) begin
            commit_en = 1'b1;
            beat_d    = '0;
            state_d   = IDLE;
          end else begin
            beat_d = beat_q + WB'(1);
          end
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {cpu_addr[AW-1:BB], {BB{1'b0}}};
        mem_wdata = st_data;
        mem_wstrb = st_be;
        if (mem_ready) begin
          cpu_ready = cpu_req;
          wr_en     = hit;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic        load_hit, load_miss;
  logic        refilled_q;
  logic [31:0] hit_q, miss_q;

  assign load_hit  = (state_q == IDLE) && cpu_req && !cpu_we && hit;
  assign load_miss = (state_q == IDLE) && cpu_req && !cpu_we && !hit;

  // A load counts once: the hit that completes a refill is not a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q      <= '0;
      miss_q     <= '0;
      refilled_q <= 1'b0;
    end else begin
      if (load_hit && !refilled_q) hit_q <= hit_q + 32'd1;
      if (load_miss) miss_q <= miss_q + 32'd1;
      if (commit_en) refilled_q <= 1'b1;
      else if (state_q == IDLE) refilled_q <= 1'b0;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule
